// File: rtl/piso_tx_if.sv
// rtl/piso_tx_if.sv - load handshake and serial output bundle for piso_tx
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             load_valid;
    logic             load_ready;
    logic [WIDTH-1:0] d;
    logic             sout;
    logic             sframe;
    logic             slast;

    modport master (
        output load_valid, d,
        input  load_ready, sout, sframe, slast
    );

    modport slave (
        input  load_valid, d,
        output load_ready, sout, sframe, slast
    );
endinterface

// File: rtl/piso_tx.sv
// rtl/piso_tx.sv - parallel-in serial-out transmitter with gapless back-to-back words
// Optional trailing even-parity bit is compiled in when PARITY_EN is defined.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic       clk,
    input  logic       clear_n,
    piso_tx_if.slave   bus
);
    localparam int             CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0]  PENULT = CW'(WIDTH - 2);

`ifdef PARITY_EN
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
    typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sout_q, sout_d;
    logic             sframe_q, sframe_d;
    logic             slast_q, slast_d;
    logic             ready;
    logic             accept;
`ifdef PARITY_EN
    logic             par_q, par_d;
`endif

    function automatic logic head(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
        return (MSB_FIRST != 0) ? (w << 1) : (w >> 1);
    endfunction

    // Ready depends only on state/counter so there is no path from load_valid.
`ifdef PARITY_EN
    assign ready = (state_q == IDLE) || (state_q == PARITY);
`else
    assign ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == LAST));
`endif
    assign accept = bus.load_valid && ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        sout_d   = 1'b0;
        sframe_d = 1'b0;
        slast_d  = 1'b0;
`ifdef PARITY_EN
        par_d    = par_q;
`endif
        // The counter always indexes the bit currently presented on sout.
        if (accept) begin
            state_d  = SHIFT;
            cnt_d    = '0;
            sout_d   = head(bus.d);
            shreg_d  = advance(bus.d);
            sframe_d = 1'b1;
`ifdef PARITY_EN
            par_d    = ^bus.d;
`endif
        end else begin
            case (state_q)
                SHIFT: begin
                    if (cnt_q != LAST) begin
                        cnt_d    = cnt_q + CW'(1);
                        sout_d   = head(shreg_q);
                        shreg_d  = advance(shreg_q);
                        sframe_d = 1'b1;
`ifdef PARITY_EN
                        slast_d  = 1'b0;
`else
                        slast_d  = (cnt_q == PENULT);
`endif
                    end else begin
`ifdef PARITY_EN
                        state_d  = PARITY;
                        sout_d   = par_q;
                        sframe_d = 1'b1;
                        slast_d  = 1'b1;
`else
                        state_d  = IDLE;
                        cnt_d    = '0;
`endif
                    end
                end
`ifdef PARITY_EN
                PARITY: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            shreg_q  <= '0;
            sout_q   <= 1'b0;
            sframe_q <= 1'b0;
            slast_q  <= 1'b0;
`ifdef PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            shreg_q  <= shreg_d;
            sout_q   <= sout_d;
            sframe_q <= sframe_d;
            slast_q  <= slast_d;
`ifdef PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    assign bus.load_ready = ready;
    assign bus.sout       = sout_q;
    assign bus.sframe     = sframe_q;
    assign bus.slast      = slast_q;
endmodule

// File: tb/tb_piso_tx.sv
// tb/tb_piso_tx.sv - directed vector bench for piso_tx, MSB-first and LSB-first instances
module tb_piso_tx;
    localparam int W = 4;
`ifdef PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         clear_n = 1'b0;
    logic         load_valid = 1'b0;
    logic [W-1:0] d = '0;
    int           checks = 0;
    int           errors = 0;

    always #5 clk = ~clk;

    piso_tx_if #(.WIDTH(W)) bm ();
    piso_tx_if #(.WIDTH(W)) bl ();

    assign bm.load_valid = load_valid;
    assign bm.d          = d;
    assign bl.load_valid = load_valid;
    assign bl.d          = d;

    piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_msb (.clk(clk), .clear_n(clear_n), .bus(bm));
    piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_lsb (.clk(clk), .clear_n(clear_n), .bus(bl));

    typedef struct {
        logic [W-1:0] d;
        logic [W-1:0] seq_msb;   // serial order, first bit in [W-1]
        logic [W-1:0] seq_lsb;
        logic         par;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [W-1:0] seq, input logic par, input int b);
        if (b < W) return seq[W-1-b];
        return par;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, " msb sout"}, 32'(bm.sout), 0);
        chk({tag, " msb sframe"}, 32'(bm.sframe), 0);
        chk({tag, " msb slast"}, 32'(bm.slast), 0);
        chk({tag, " msb ready"}, 32'(bm.load_ready), 1);
        chk({tag, " lsb sframe"}, 32'(bl.sframe), 0);
        chk({tag, " lsb ready"}, 32'(bl.load_ready), 1);
    endtask

    initial begin
        vecs[0] = '{d: 4'b1011, seq_msb: 4'b1011, seq_lsb: 4'b1101, par: 1'b1};
        vecs[1] = '{d: 4'b1001, seq_msb: 4'b1001, seq_lsb: 4'b1001, par: 1'b0};
        vecs[2] = '{d: 4'b1100, seq_msb: 4'b1100, seq_lsb: 4'b0011, par: 1'b0};
        vecs[3] = '{d: 4'b0110, seq_msb: 4'b0110, seq_lsb: 4'b0110, par: 1'b0};
        vecs[4] = '{d: 4'b0001, seq_msb: 4'b0001, seq_lsb: 4'b1000, par: 1'b1};

        #1;
        chk_idle("reset");
        @(negedge clk);
        clear_n = 1'b1;

        // Single words on both bit orders; d and load_valid are disturbed mid-frame.
        for (int v = 0; v < 5; v++) begin
            @(negedge clk);
            load_valid = 1'b1;
            d = vecs[v].d;
            @(posedge clk);
            #1;
            for (int b = 0; b < FL; b++) begin
                chk($sformatf("v%0d b%0d msb sout", v, b), 32'(bm.sout),
                    32'(exp_bit(vecs[v].seq_msb, vecs[v].par, b)));
                chk($sformatf("v%0d b%0d lsb sout", v, b), 32'(bl.sout),
                    32'(exp_bit(vecs[v].seq_lsb, vecs[v].par, b)));
                chk($sformatf("v%0d b%0d sframe", v, b), 32'(bm.sframe), 1);
                chk($sformatf("v%0d b%0d slast", v, b), 32'(bm.slast), 32'(b == FL - 1));
                chk($sformatf("v%0d b%0d ready", v, b), 32'(bm.load_ready), 32'(b == FL - 1));
                chk($sformatf("v%0d b%0d lsb slast", v, b), 32'(bl.slast), 32'(b == FL - 1));
                if (b < FL - 1) begin
                    load_valid = (b % 2) == 0;
                    d = ~vecs[v].d;
                end else begin
                    load_valid = 1'b0;
                end
                @(posedge clk);
                #1;
            end
            chk_idle($sformatf("v%0d end", v));
        end

        // Back-to-back: second word presented on the slast cycle.
        @(negedge clk);
        load_valid = 1'b1;
        d = 4'b1100;
        @(posedge clk);
        #1;
        for (int b = 0; b < 2 * FL; b++) begin
            if (b < FL)
                chk($sformatf("b2b b%0d sout", b), 32'(bm.sout), 32'(exp_bit(4'b1100, 1'b0, b)));
            else
                chk($sformatf("b2b b%0d sout", b), 32'(bm.sout), 32'(exp_bit(4'b0011, 1'b0, b - FL)));
            chk($sformatf("b2b b%0d sframe", b), 32'(bm.sframe), 1);
            chk($sformatf("b2b b%0d slast", b), 32'(bm.slast), 32'((b == FL - 1) || (b == 2 * FL - 1)));
            if (b == FL - 1) d = 4'b0011;
            if (b == 2 * FL - 1) load_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        chk_idle("b2b end");

        // Asynchronous reset mid-frame, between clock edges.
        @(negedge clk);
        load_valid = 1'b1;
        d = 4'b1111;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk("pre-reset sframe", 32'(bm.sframe), 1);
        @(posedge clk);
        #3;
        clear_n = 1'b0;
        #1;
        chk_idle("mid-frame reset");
        @(negedge clk);
        clear_n = 1'b1;
        load_valid = 1'b1;
        d = 4'b1001;
        @(posedge clk);
        #1;
        load_valid = 1'b0;
        chk("post-reset msb sout", 32'(bm.sout), 1);
        chk("post-reset lsb sout", 32'(bl.sout), 1);
        chk("post-reset sframe", 32'(bm.sframe), 1);
        chk("post-reset slast", 32'(bm.slast), 0);
        chk("post-reset ready", 32'(bm.load_ready), 0);
        repeat (FL) @(posedge clk);
        #1;
        chk_idle("post-reset end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
